// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam int DW_BYTES  = 8;
    localparam int DW_SHIFT  = 3;
    localparam int LAT_CNT_W = 4;
    function automatic logic misaligned(input logic [DW_SHIFT-1:0] lo);
        return lo != '0;
    endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port doubleword store with per-byte write enables and registered read
module dmem_array
    import dmem_pkg::*;
#(
    parameter int IDX_W  = 7,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                en,
    input  logic                we,
    input  logic [DW_BYTES-1:0] wstrb,
    input  logic [IDX_W-1:0]    idx,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);
    logic [DATA_W-1:0] mem [2**IDX_W];
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int b = 0; b < DW_BYTES; b++)
                if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
        if (en && !we) rdata <= mem[idx];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: one-at-a-time load/store responder with fixed access latency
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 64,
    parameter int LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DW_BYTES-1:0] req_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                busy
);
    localparam int IDX_W = ADDR_W - DW_SHIFT;
    localparam logic [LAT_CNT_W-1:0] CNT_INIT = LATENCY > 1 ? LAT_CNT_W'(LATENCY - 2) : '0;
    state_t state_q, state_d;
    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
    logic rsp_valid_q, rsp_valid_d;
    logic accept, commit;
    logic we_q, err_q;
    logic [IDX_W-1:0] idx_q;
    logic [DATA_W-1:0] wdata_q, arr_rdata;
    logic [DW_BYTES-1:0] wstrb_q;
    assign req_ready = state_q == IDLE && !rst;
    assign accept    = req_valid && req_ready;
    assign busy      = state_q != IDLE;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_valid_q && err_q;
    assign rsp_rdata = rsp_valid_q && !we_q && !err_q ? arr_rdata : '0;
    // RESP with rsp_valid still low is the commit cycle; its closing edge accesses the array
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        commit      = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                state_d = LATENCY == 1 ? RESP : WAIT;
                cnt_d   = CNT_INIT;
            end
            WAIT: begin
                state_d = cnt_q == '0 ? RESP : WAIT;
                cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
            end
            RESP: begin
                commit      = !rsp_valid_q;
                rsp_valid_d = !rsp_valid_q || !rsp_ready;
                state_d     = rsp_valid_q && rsp_ready ? IDLE : RESP;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            err_q   <= misaligned(req_addr[DW_SHIFT-1:0]);
            idx_q   <= req_addr[ADDR_W-1:DW_SHIFT];
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
        end
    end
    dmem_array #(.IDX_W(IDX_W), .DATA_W(DATA_W)) u_array (
        .clk   (clk),
        .en    (commit && !err_q && !rst),
        .we    (we_q),
        .wstrb (wstrb_q),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized checks against a byte-level memory model
module tb_dmem_responder;
    localparam int LAT = 2;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [9:0]  req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err, busy;
    logic [63:0] rsp_rdata;
    logic [63:0] mem_m [128];
    int vec = 0, miss = 0;

    dmem_responder #(.ADDR_W(10), .DATA_W(64), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xact(input logic we, input logic [9:0] addr, input logic [63:0] wd,
                        input logic [7:0] ws, input int hold);
        logic        e;
        logic [63:0] d;
        int          n;
        e = addr[2:0] != 3'd0;
        d = (!we && !e) ? mem_m[addr[9:3]] : 64'd0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws;
        chk("ready_before_accept", req_ready, 1);
        tick();
        req_valid = 1'b0;
        req_wdata = ~wd;
        chk("busy_after_accept", busy, 1);
        chk("ready_after_accept", req_ready, 0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("latency", 64'(n), 64'(LAT));
        chk("rdata", rsp_rdata, d);
        chk("err", rsp_err, e);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", rsp_valid, 1);
            chk("hold_rdata", rsp_rdata, d);
            chk("hold_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("valid_dropped", rsp_valid, 0);
        chk("ready_returned", req_ready, 1);
        chk("busy_cleared", busy, 0);
        if (we && !e)
            for (int b = 0; b < 8; b++)
                if (ws[b]) mem_m[addr[9:3]][8*b +: 8] = wd[8*b +: 8];
    endtask

    initial begin
        logic [9:0]  a;
        logic [63:0] w;
        rst = 1'b1;
        tick();
        chk("rst_ready", req_ready, 0);
        tick();
        chk("rst_ready2", req_ready, 0);
        chk("rst_valid", rsp_valid, 0);
        rst = 1'b0;
        #1;
        chk("idle_ready", req_ready, 1);
        chk("idle_valid", rsp_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_rdata", rsp_rdata, 0);
        chk("idle_err", rsp_err, 0);

        xact(1'b1, 10'h010, 64'h1122334455667788, 8'hFF, 0);
        xact(1'b0, 10'h010, 64'h0, 8'h00, 0);
        chk("store_load_model", mem_m[2], 64'h1122334455667788);
        xact(1'b1, 10'h010, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0);
        xact(1'b0, 10'h010, 64'h0, 8'h00, 0);
        chk("partial_model", mem_m[2], 64'h11223344AAAAAAAA);
        xact(1'b0, 10'h010, 64'h0, 8'h00, 5);

        xact(1'b1, 10'h018, 64'h0123456789ABCDEF, 8'hFF, 0);
        xact(1'b0, 10'h013, 64'h0, 8'h00, 0);
        xact(1'b1, 10'h01C, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 0);
        xact(1'b0, 10'h018, 64'h0, 8'h00, 0);
        xact(1'b1, 10'h018, 64'h5555555555555555, 8'h00, 1);
        xact(1'b0, 10'h018, 64'h0, 8'h00, 0);

        xact(1'b1, 10'h020, 64'hCAFEF00D12345678, 8'hFF, 0);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h020; req_wdata = 64'hDEAD; req_wstrb = 8'hFF;
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("abort_ready_in_rst", req_ready, 0);
        rst = 1'b0;
        #1;
        chk("abort_valid", rsp_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", req_ready, 1);
        chk("abort_err", rsp_err, 0);
        tick();
        chk("abort_quiet", rsp_valid, 0);
        xact(1'b0, 10'h020, 64'h0, 8'h00, 0);

        for (int i = 0; i < 128; i++) begin
            w = {$urandom, $urandom};
            xact(1'b1, 10'(i << 3), w, 8'hFF, 0);
        end
        for (int i = 0; i < 300; i++) begin
            a = 10'($urandom_range(0, 127) << 3);
            if ($urandom_range(0, 7) == 0) a[2:0] = 3'($urandom_range(1, 7));
            w = {$urandom, $urandom};
            xact(1'($urandom_range(0, 1)), a, w, 8'($urandom_range(0, 255)), $urandom_range(0, 2));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
